// File: rtl/cmd_sender_if.sv
// cmd_sender_if: command request/status bundle between a host and cmd_sender.
interface cmd_sender_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        TX;
    logic        busy;
    logic        cmd_sent;
    modport master (output cmd, snd_cmd, input TX, busy, cmd_sent);
    modport slave (input cmd, snd_cmd, output TX, busy, cmd_sent);
endinterface

// File: rtl/cmd_sender.sv
// cmd_sender: sends a 16-bit command as two 8N1 UART frames on TX, high byte first.
// Define CMD_CHKSUM_EN to append a third frame carrying high^low byte.
module cmd_sender #(
    parameter int BAUD_DIV = 2604
) (
    input logic         clk,
    input logic         rst_n,
    cmd_sender_if.slave bus
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
`ifdef CMD_CHKSUM_EN
    localparam int HOLD_W = 16;
    typedef enum logic [1:0] {IDLE, HI_BYTE, LO_BYTE, CHK_BYTE} state_t;
`else
    localparam int HOLD_W = 8;
    typedef enum logic [1:0] {IDLE, HI_BYTE, LO_BYTE} state_t;
`endif
    state_t              state_q, state_d, next_state;
    logic [HOLD_W-1:0]   cmd_hold_q, cmd_hold_d;
    logic [15:0]         baud_cnt_q, baud_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [8:0]          shift_q, shift_d;
    logic                cmd_sent_q, cmd_sent_d;
    logic [7:0]          next_byte;
    logic                bit_end;

    assign bit_end      = baud_cnt_q == BAUD_LAST;
    assign bus.TX       = shift_q[0];
    assign bus.busy     = state_q != IDLE;
    assign bus.cmd_sent = cmd_sent_q;

    // Which frame follows the one on the line; the high byte goes straight into
    // the shifter on accept, so only later bytes come from cmd_hold.
    always_comb begin
        next_state = IDLE;
        next_byte  = cmd_hold_q[7:0];
        case (state_q)
            HI_BYTE: next_state = LO_BYTE;
`ifdef CMD_CHKSUM_EN
            LO_BYTE: begin
                next_state = CHK_BYTE;
                next_byte  = cmd_hold_q[15:8] ^ cmd_hold_q[7:0];
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Accept, baud/bit timing, shifting and frame sequencing.
    always_comb begin
        state_d    = state_q;
        cmd_hold_d = cmd_hold_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_sent_d = cmd_sent_q;
        if (state_q == IDLE) begin
            if (bus.snd_cmd) begin
                state_d    = HI_BYTE;
                cmd_hold_d = bus.cmd[HOLD_W-1:0];
                shift_d    = {bus.cmd[15:8], 1'b0};
                cmd_sent_d = 1'b0;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        end else if (!bit_end) begin
            baud_cnt_d = baud_cnt_q + 16'd1;
        end else begin
            baud_cnt_d = '0;
            if (bit_cnt_q != 4'd9) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {1'b1, shift_q[8:1]};
            end else begin
                bit_cnt_d = '0;
                state_d   = next_state;
                shift_d   = next_state == IDLE ? 9'h1FF : {next_byte, 1'b0};
                if (next_state == IDLE) cmd_sent_d = 1'b1;
            end
        end
    end

    // State register; async reset forces TX high and abandons any command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_hold_q <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= 9'h1FF;
            cmd_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_hold_q <= cmd_hold_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end
endmodule

// File: tb/tb_cmd_sender.sv
// tb_cmd_sender: randomized and directed checks of cmd_sender against a frame-list model.
module tb_cmd_sender;
    localparam int BD = 16;
`ifdef CMD_CHKSUM_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif
    localparam int CMD_CLKS = NF * 10 * BD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    cmd_sender_if bus();
    cmd_sender #(.BAUD_DIV(BD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   run = 0;
    logic prev_busy = 1'b0;
    logic exp_q[$];
    logic exp_sent = 1'b0;
    logic tx_log[$];
    int   starts[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < BD; j++) exp_q.push_back(f[i]);
    endfunction

    task automatic step(input logic s, input logic [15:0] c);
        logic exp_tx;
        bus.snd_cmd = s;
        bus.cmd = c;
        @(posedge clk);
        cyc++;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_sent = 1'b1;
        end else if (s) begin
            push_frame(c[15:8]);
            push_frame(c[7:0]);
`ifdef CMD_CHKSUM_EN
            push_frame(c[15:8] ^ c[7:0]);
`endif
            exp_sent = 1'b0;
        end
        @(negedge clk);
        exp_tx = 1'b1;
        if (exp_q.size() != 0) exp_tx = exp_q[0];
        check("tx", 32'(bus.TX), 32'(exp_tx));
        check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
        check("cmd_sent", 32'(bus.cmd_sent), 32'(exp_sent));
        if (bus.busy) begin
            if (!prev_busy) starts.push_back(cyc);
            run++;
            tx_log.push_back(bus.TX);
        end else if (prev_busy) begin
            check("busy_len", run, CMD_CLKS);
            run = 0;
        end
        prev_busy = bus.busy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_sent = 1'b0;
        prev_busy = 1'b0;
        run = 0;
        check("rst_tx", 32'(bus.TX), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sent", 32'(bus.cmd_sent), 32'd0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:19] a5c3_bits;
        a5c3_bits = 20'b0101001011_0110000111;
        bus.snd_cmd = 1'b0;
        bus.cmd = '0;
        @(negedge clk);
        do_reset(3);
        idle(5);

        tx_log.delete();
        step(1'b1, 16'hA5C3);
        idle(CMD_CLKS + 10);
        check("basic_log", tx_log.size(), CMD_CLKS);
        if (tx_log.size() >= 20 * BD)
            for (int i = 0; i < 20; i++) check("basic_bit", 32'(tx_log[i * BD + BD / 2]), 32'(a5c3_bits[i]));

        step(1'b1, 16'h1234);
        for (int i = 1; i < CMD_CLKS + 40; i++) step(i == 100, i == 100 ? 16'hFFFF : 16'($urandom));

        starts.delete();
        step(1'b1, 16'h00FF);
        for (int i = 0; i < CMD_CLKS + 5; i++) step(1'b1, 16'hFF00);
        idle(CMD_CLKS + 10);
        check("b2b_starts", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], CMD_CLKS + 1);

        step(1'b1, 16'($urandom));
        idle(149);
        do_reset(4);
        idle(40);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 400; i++) step($urandom_range(0, 15) == 0, 16'($urandom));
            if (k == 7) begin
                idle($urandom_range(1, CMD_CLKS));
                do_reset(2);
            end
        end
        idle(CMD_CLKS + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
